// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path.
// Used by seg_scan_ctrl, its prescaler and the downstream BCD decoder.
package seg_pkg;

    localparam int BCD_W = 4;

    // Decoder code that turns every segment off.
    localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

    // Digit enable levels (enables are active-low).
    localparam logic DIG_ON  = 1'b0;
    localparam logic DIG_OFF = 1'b1;

endpackage : seg_pkg

// File: rtl/seg_scan_ctrl_prescaler.sv
// scan_prescaler: free-running divider that marks the last cycle of each scan slot.
// cnt runs 0..DIV-1 and wraps. tick is high only in the cycle where cnt == DIV-1.
// tick is registered, so it is decoded one cycle early from cnt == DIV-2.
module scan_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(DIV - 2);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Slot counter, wrapping at DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1'b1);
        end
    end

    // Registered end-of-slot strobe; high while cnt_r == DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_r <= 1'b0;
        end else begin
            tick_r <= (cnt_r == CNT_PRE);
        end
    end

    assign tick = tick_r;

endmodule : scan_prescaler

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for the fare readout.
// It latches one frame of BCD digits and the max flag when the digit index wraps.
// Each slot presents one digit to the decoder. Each slot has a 2-cycle ghost-blank
// window before the active-low enable for that digit goes low.
// Optional build macro: SEG_LZB_EN enables leading-zero blanking.
// Leading-zero blanking is suppressed while the frame's max flag is set.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int CLK_HZ  = 50_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BCD_W*DIGITS-1:0] bcd_in,
    input  logic                    max_in,
    output logic [BCD_W-1:0]        bcd_out,
    output logic                    max_out,
    output logic [DIGITS-1:0]       dig_sel
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    if (DIV < 3) begin : g_div_chk
        $error("seg_scan_ctrl: CLK_HZ/SCAN_HZ must be at least 3");
    end
    if ((DIGITS < 2) || (DIGITS > 8)) begin : g_dig_chk
        $error("seg_scan_ctrl: DIGITS must be in 2..8");
    end

    logic                          tick_s;
    logic [IW-1:0]                 idx_r;
    logic [DIGITS-1:0][BCD_W-1:0]  shadow_r;
    logic                          shadow_max_r;
    logic                          e1_r;
    logic                          e2_r;
    logic [DIGITS-1:0]             lz_s;
    logic [BCD_W-1:0]              digit_s;
    logic [DIGITS-1:0]             sel_s;

    scan_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Slot index advance (E0) and frame load when the index wraps to digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r        <= IDX_LAST;
            shadow_r     <= {(BCD_W*DIGITS){1'b0}};
            shadow_max_r <= 1'b0;
        end else if (tick_s) begin
            if (idx_r == IDX_LAST) begin
                idx_r        <= {IW{1'b0}};
                shadow_r     <= bcd_in;
                shadow_max_r <= max_in;
            end else begin
                idx_r        <= idx_r + IW'(1'b1);
            end
        end
    end

    // Delayed tick strobes marking E1 (digit update) and E2 (enable on).
    always_ff @(posedge clk) begin
        if (rst) begin
            e1_r <= 1'b0;
            e2_r <= 1'b0;
        end else begin
            e1_r <= tick_s;
            e2_r <= e1_r;
        end
    end

`ifdef SEG_LZB_EN
    logic above_zero_s;

    // Flag zero digits that have only zeros above them; digit 0 is never flagged.
    always_comb begin
        lz_s         = {DIGITS{1'b0}};
        above_zero_s = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            above_zero_s = above_zero_s & (shadow_r[k] == {BCD_W{1'b0}});
            lz_s[k]      = above_zero_s;
        end
    end
`else
    // Leading-zero blanking is compiled out: no digit is ever flagged.
    always_comb begin
        lz_s = {DIGITS{1'b0}};
    end
`endif

    // Digit mux with blanking; a saturated fare always shows every digit.
    always_comb begin
        digit_s = shadow_r[idx_r];
        if (lz_s[idx_r] && !shadow_max_r) begin
            digit_s = BCD_BLANK;
        end else begin
            digit_s = shadow_r[idx_r];
        end
    end

    // Active-low one-hot enable for the current slot.
    always_comb begin
        sel_s        = {DIGITS{DIG_OFF}};
        sel_s[idx_r] = DIG_ON;
    end

    // Output registers: blank at E0, new digit at E1, enable at E2.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_out <= BCD_BLANK;
            max_out <= 1'b0;
            dig_sel <= {DIGITS{DIG_OFF}};
        end else begin
            if (tick_s) begin
                dig_sel <= {DIGITS{DIG_OFF}};
            end else if (e2_r) begin
                dig_sel <= sel_s;
            end
            if (e1_r) begin
                bcd_out <= digit_s;
                max_out <= shadow_max_r;
            end
        end
    end

endmodule : seg_scan_ctrl
